// File: rtl/clk_div_pkg.sv
// Shared types and defaults for the clock divider and its period meter.
// Provides the meter FSM state encoding and counter sizing.
package clk_div_pkg;
  localparam int CNT_W_DEF   = 32;
  localparam int TIMEOUT_DEF = 1024;

  typedef enum logic [1:0] {
    IDLE,
    WAIT_RISE,
    MEASURE,
    DONE
  } state_t;
endpackage

// File: rtl/clock_period_meter_if.sv
// Control and result bundle of the clock period meter.
// master drives requests, slave is the meter.
interface clock_period_meter_if
  import clk_div_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF
);
  logic             start;
  logic             continuous;
  logic [CNT_W-1:0] expected_ratio;
  logic [7:0]       tolerance;
  logic             busy;
  logic             meas_valid;
  logic [CNT_W-1:0] period;
  logic [CNT_W-1:0] high_time;
  logic             mismatch;
  logic             timeout;

  modport master (
    output start, continuous,
    output expected_ratio, tolerance,
    input  busy, meas_valid,
    input  period, high_time,
    input  mismatch, timeout
  );

  modport slave (
    input  start, continuous,
    input  expected_ratio, tolerance,
    output busy, meas_valid,
    output period, high_time,
    output mismatch, timeout
  );
endinterface

// File: rtl/sync_edge_detect.sv
// Multi-flop synchroniser for an asynchronous level with
// rise/fall pulses; both edges see the same latency.
module sync_edge_detect #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic i_async,
  output logic o_rise,
  output logic o_fall
);
  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_s_d;
  logic                   w_s;

  assign w_s = r_sync[SYNC_STAGES-1];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync <= '0;
      r_s_d  <= 1'b0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], i_async};
      r_s_d  <= w_s;
    end
  end

  assign o_rise = w_s & ~r_s_d;
  assign o_fall = ~w_s & r_s_d;
endmodule

// File: rtl/clock_period_meter.sv
// Measures period and high time of an asynchronous divided clock
// in clk_in cycles and flags deviation from the expected ratio.
module clock_period_meter
  import clk_div_pkg::*;
#(
  parameter int CNT_W       = CNT_W_DEF,
  parameter int SYNC_STAGES = 2,
  parameter int TIMEOUT_CYC = TIMEOUT_DEF
) (
  input  logic                 clk_in,
  input  logic                 reset,
  input  logic                 div_clk,
  clock_period_meter_if.slave  bus
);
  localparam logic [CNT_W-1:0] TMO = CNT_W'(TIMEOUT_CYC);

  state_t            r_state;
  state_t            w_state_nxt;
  logic [CNT_W-1:0]  r_cnt;
  logic [CNT_W-1:0]  r_exp;
  logic [7:0]        r_tol;
  logic [CNT_W-1:0]  r_high_acc;
  logic [CNT_W-1:0]  r_period;
  logic [CNT_W-1:0]  r_high_time;
  logic              r_mismatch;
  logic              r_timeout;
  logic              w_rise;
  logic              w_fall;
  logic              w_accept;
  logic              w_end;
  logic              w_tmo;
  logic signed [CNT_W:0] w_diff;
  logic [CNT_W:0]    w_abs;
  logic              w_mis;

  sync_edge_detect #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync (
    .clk     (clk_in),
    .rst     (reset),
    .i_async (div_clk),
    .o_rise  (w_rise),
    .o_fall  (w_fall)
  );

  // Wide signed difference so the error magnitude never wraps.
  always_comb begin
    w_diff = $signed({1'b0, r_cnt})
           - $signed({1'b0, r_exp});
    w_abs  = w_diff[CNT_W] ? $unsigned(-w_diff)
                           : $unsigned(w_diff);
    w_mis  = w_abs > {{(CNT_W-7){1'b0}}, r_tol};
  end

  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_end       = 1'b0;
    w_tmo       = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (bus.start) begin
          w_accept    = 1'b1;
          w_state_nxt = WAIT_RISE;
        end
      end
      WAIT_RISE: begin
        if (w_rise) begin
          w_state_nxt = MEASURE;
        end else if (r_cnt == TMO) begin
          w_tmo       = 1'b1;
          w_state_nxt = DONE;
        end
      end
      MEASURE: begin
        if (w_rise) begin
          w_end       = 1'b1;
          w_state_nxt = DONE;
        end else if (r_cnt == TMO) begin
          w_tmo       = 1'b1;
          w_state_nxt = DONE;
        end
      end
      DONE: begin
        if (bus.continuous && !r_timeout)
          w_state_nxt = MEASURE;
        else
          w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (reset) begin
      r_state     <= IDLE;
      r_cnt       <= '0;
      r_exp       <= '0;
      r_tol       <= '0;
      r_high_acc  <= '0;
      r_period    <= '0;
      r_high_time <= '0;
      r_mismatch  <= 1'b0;
      r_timeout   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      unique case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_exp      <= bus.expected_ratio;
            r_tol      <= bus.tolerance;
            r_cnt      <= '0;
            r_high_acc <= '0;
          end
        end
        WAIT_RISE: begin
          r_cnt <= w_rise ? CNT_W'(1)
                          : r_cnt + CNT_W'(1);
        end
        MEASURE: begin
          r_cnt <= r_cnt + CNT_W'(1);
          if (w_fall) r_high_acc <= r_cnt;
        end
        DONE: begin
          // DONE is cycle 1 of a back-to-back measurement.
          r_cnt      <= CNT_W'(2);
          r_high_acc <= w_fall ? CNT_W'(1) : '0;
        end
        default: r_cnt <= '0;
      endcase
      if (w_end || w_tmo) begin
        r_timeout   <= w_tmo;
        r_mismatch  <= w_tmo | w_mis;
        r_period    <= w_tmo ? '0 : r_cnt;
        r_high_time <= r_high_acc;
      end
    end
  end

  assign bus.busy       = (r_state != IDLE);
  assign bus.meas_valid = (r_state == DONE);
  assign bus.period     = r_period;
  assign bus.high_time  = r_high_time;
  assign bus.mismatch   = r_mismatch;
  assign bus.timeout    = r_timeout;
endmodule

// File: tb/tb_clock_period_meter.sv
// Directed bench for clock_period_meter with a synchronous
// divider model and a result scoreboard.
module tb_clock_period_meter;
  localparam int TMO = 1024;

  typedef struct packed {
    logic [31:0] period;
    logic [31:0] high;
    logic        mis;
    logic        tmo;
  } exp_t;

  logic clk_in = 1'b0;
  logic reset  = 1'b1;
  logic div_clk = 1'b0;
  int   ratio  = 10;
  bit   div_en = 1'b0;
  int   dcnt   = 0;
  int   cyc    = 0;
  int   n_cmp  = 0;
  int   n_err  = 0;
  int   n_val  = 0;
  exp_t sb[$];
  exp_t e_mon;

  clock_period_meter_if #(.CNT_W(32)) bus ();

  clock_period_meter #(
    .CNT_W(32),
    .SYNC_STAGES(2),
    .TIMEOUT_CYC(TMO)
  ) dut (
    .clk_in  (clk_in),
    .reset   (reset),
    .div_clk (div_clk),
    .bus     (bus)
  );

  always #5 clk_in = ~clk_in;
  always @(posedge clk_in) cyc <= cyc + 1;

  always @(negedge clk_in) begin
    if (!div_en) begin
      dcnt    = 0;
      div_clk = 1'b0;
    end else begin
      div_clk = (dcnt < (ratio + 1) / 2);
      dcnt    = (dcnt + 1 >= ratio) ? 0 : dcnt + 1;
    end
  end

  task automatic check(input string tag,
                       input logic [63:0] obs,
                       input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d",
             tag, obs, exp);
    end
  endtask

  always @(negedge clk_in) begin
    if (bus.meas_valid === 1'b1) begin
      n_val++;
      if (sb.size() == 0) begin
        check("unexpected_valid", 64'd1, 64'd0);
      end else begin
        e_mon = sb.pop_front();
        check("period", 64'(bus.period), 64'(e_mon.period));
        check("high_time", 64'(bus.high_time), 64'(e_mon.high));
        check("mismatch", 64'(bus.mismatch), 64'(e_mon.mis));
        check("timeout", 64'(bus.timeout), 64'(e_mon.tmo));
      end
    end
  end

  function automatic exp_t model(input int r, input int x,
                                 input int tol);
    exp_t m;
    int   d;
    d       = (r > x) ? r - x : x - r;
    m.period = 32'(r);
    m.high   = 32'((r + 1) / 2);
    m.mis    = (d > tol);
    m.tmo    = 1'b0;
    return m;
  endfunction

  task automatic wait_idle(input string tag);
    bit done;
    done = 1'b0;
    for (int i = 0; i < 3000 && !done; i++) begin
      @(negedge clk_in);
      if (!bus.busy) done = 1'b1;
    end
    if (!done) check({tag, "_idle_tmo"}, 64'd0, 64'd1);
  endtask

  task automatic measure(input string tag, input int x,
                         input int tol);
    sb.push_back(model(ratio, x, tol));
    @(negedge clk_in);
    bus.expected_ratio = 32'(x);
    bus.tolerance      = 8'(tol);
    bus.start          = 1'b1;
    @(negedge clk_in);
    bus.start = 1'b0;
    wait_idle(tag);
    repeat (2) @(negedge clk_in);
    check({tag, "_drain"}, 64'(sb.size()), 64'd0);
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_busy"}, 64'(bus.busy), 64'd0);
    check({tag, "_valid"}, 64'(bus.meas_valid), 64'd0);
    check({tag, "_period"}, 64'(bus.period), 64'd0);
    check({tag, "_high"}, 64'(bus.high_time), 64'd0);
    check({tag, "_mis"}, 64'(bus.mismatch), 64'd0);
    check({tag, "_tmo"}, 64'(bus.timeout), 64'd0);
  endtask

  initial begin
    int n;
    int k;
    int last;
    bit pulsed;
    exp_t t;
    bus.start          = 1'b0;
    bus.continuous     = 1'b0;
    bus.expected_ratio = '0;
    bus.tolerance      = '0;
    repeat (3) @(posedge clk_in);
    #1 check_zero("reset");
    @(negedge clk_in);
    reset  = 1'b0;
    div_en = 1'b1;
    repeat (30) @(negedge clk_in);

    ratio = 10;
    measure("r10", 10, 0);
    ratio = 7;
    repeat (20) @(negedge clk_in);
    measure("r7", 7, 0);
    ratio = 12;
    repeat (20) @(negedge clk_in);
    measure("r12_t1", 10, 1);
    measure("r12_t2", 10, 2);
    ratio = 7;
    repeat (20) @(negedge clk_in);
    measure("exp0", 0, 5);

    // div_clk stuck low: expect an aborted measurement
    div_en = 1'b0;
    repeat (10) @(negedge clk_in);
    t = '{period: 32'd0, high: 32'd0, mis: 1'b1, tmo: 1'b1};
    sb.push_back(t);
    bus.expected_ratio = 32'd10;
    bus.tolerance      = 8'd0;
    bus.start          = 1'b1;
    @(posedge clk_in);
    #1 bus.start = 1'b0;
    n = 0;
    while (bus.meas_valid !== 1'b1 && n < 3000) begin
      @(posedge clk_in);
      #1 n++;
    end
    check("tmo_latency", 64'(n), 64'(TMO + 1));
    wait_idle("tmo");
    check("tmo_drain", 64'(sb.size()), 64'd0);

    ratio  = 10;
    div_en = 1'b1;
    repeat (30) @(negedge clk_in);
    for (int i = 0; i < 3; i++) sb.push_back(model(10, 10, 0));
    bus.expected_ratio = 32'd10;
    bus.tolerance      = 8'd0;
    bus.continuous     = 1'b1;
    bus.start          = 1'b1;
    @(negedge clk_in);
    bus.start = 1'b0;
    k = 0; last = 0; pulsed = 1'b0; n = 0;
    while (k < 3 && n < 300) begin
      @(negedge clk_in);
      n++;
      if (bus.meas_valid === 1'b1) begin
        if (k > 0) check("cont_spacing", 64'(cyc - last), 64'd10);
        last = cyc;
        k++;
        if (k == 3) bus.continuous = 1'b0;
      end
      if (k == 1 && !pulsed) begin
        bus.start          = 1'b1;
        bus.expected_ratio = 32'd3;
        pulsed             = 1'b1;
      end else begin
        bus.start          = 1'b0;
        bus.expected_ratio = 32'd10;
      end
    end
    check("cont_count", 64'(k), 64'd3);
    wait_idle("cont");
    repeat (15) @(negedge clk_in);
    check("cont_drain", 64'(sb.size()), 64'd0);

    // reset while the measurement is in progress
    ratio  = 20;
    div_en = 1'b0;
    repeat (10) @(negedge clk_in);
    bus.expected_ratio = 32'd20;
    bus.start          = 1'b1;
    div_en             = 1'b1;
    @(negedge clk_in);
    bus.start = 1'b0;
    repeat (12) @(negedge clk_in);
    check("pre_rst_busy", 64'(bus.busy), 64'd1);
    n = n_val;
    reset = 1'b1;
    @(posedge clk_in);
    #1 check_zero("midrst");
    @(negedge clk_in);
    reset = 1'b0;
    repeat (60) @(negedge clk_in);
    check("midrst_novalid", 64'(n_val - n), 64'd0);
    measure("post_rst", 20, 0);

    check("final_drain", 64'(sb.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/clock_period_meter.md
# clock_period_meter

Downstream monitor for the clock divider's `clk_out`. It treats the divided clock as an asynchronous input and synchronises it into the `clk_in` domain. It then measures period and high time in `clk_in` cycles and flags deviation from the programmed divide ratio. It is used in-system and on the bench to confirm that the divider output matches `ratio`.

## Interface
Parameters:
- `CNT_W`, 32: width of counters, ratio and results.
- `SYNC_STAGES`, 2: synchroniser depth, minimum 2.
- `TIMEOUT_CYC`, 1024: cycles without the expected edge before `timeout` is raised. Must be below 2^CNT_W.

Ports:
- `clk_in`, in, 1: system clock, the only clock.
- `reset`, in, 1: synchronous, active-high reset. Clears all state on the next `clk_in` rising edge.
- `div_clk`, in, 1: divided clock under test. Asynchronous; never used as a clock.
- `start`, in, 1: single-cycle request to begin a measurement. Ignored while `busy`.
- `continuous`, in, 1: when 1, the block re-measures back-to-back without a new `start`.
- `expected_ratio`, in, CNT_W: nominal period. Sampled on accepted `start`.
- `tolerance`, in, 8: allowed absolute period error. Sampled on accepted `start`.
- `busy`, out, 1: high outside IDLE.
- `meas_valid`, out, 1: single-cycle strobe; results are valid on this cycle.
- `period`, out, CNT_W: `clk_in` cycles between consecutive rising edges.
- `high_time`, out, CNT_W: `clk_in` cycles from a rising edge to the following falling edge.
- `mismatch`, out, 1: asserted when |period − expected_ratio| > tolerance.
- `timeout`, out, 1: asserted when the measurement was aborted.

## Operation
Edge detection:
- `div_clk` passes through a SYNC_STAGES flop chain, giving `s`. A further register holds `s_d`.
- `rise = s & ~s_d`; `fall = ~s & s_d`.

State machine:
- **IDLE**:
  - On `start`, latch `expected_ratio` and `tolerance`, clear `cnt`, and go to WAIT_RISE.
- **WAIT_RISE**:
  - `cnt` increments every cycle.
  - On `rise`, set `cnt` <= 1 and go to MEASURE.
  - If `cnt` reaches TIMEOUT_CYC first, go to DONE with `timeout` = 1.
- **MEASURE**:
  - `cnt` increments every cycle.
  - On `fall`, `high_time` <= `cnt`.
  - On `rise`, `period` <= `cnt` and go to DONE.
  - If `cnt` reaches TIMEOUT_CYC first, go to DONE with `timeout` = 1 and `period` = 0.
- **DONE** (one cycle):
  - `meas_valid` = 1.
  - If `continuous` = 1 and `timeout` = 0, go to MEASURE with `cnt` <= 2, which counts the DONE cycle.
  - Otherwise go to IDLE.

Arithmetic and flags:
- `mismatch` is computed at the DONE transition using a CNT_W+1-bit signed difference.
- `mismatch` is forced to 1 when `timeout` = 1.
- If no `fall` occurs during MEASURE, `high_time` is 0.

Boundary conditions:
- `start` while `busy`: ignored; latched parameters are unchanged.
- Reset mid-measurement: the next cycle is IDLE with all outputs 0, and no `meas_valid` is issued.
- `rise` and timeout on the same cycle: `rise` wins and the measurement is normal.
- `expected_ratio` = 0: legal; any period greater than `tolerance` mismatches.
- Results hold their values until the next DONE.

## Timing
- Reset values: `busy`, `meas_valid`, `mismatch` and `timeout` are 0; `period` and `high_time` are 0; the synchroniser flops are 0.
- Edge-to-detect latency is SYNC_STAGES + 1 cycles. Latency is identical for rise and fall, so `period` and `high_time` are unbiased.
- `meas_valid` rises 1 cycle after the terminating `rise` is detected and lasts exactly 1 cycle.
- In continuous mode, strobes are spaced exactly `period` cycles apart for a stable input.
- Resolution is ±1 `clk_in` cycle for an asynchronous `div_clk`. It is exact when `div_clk` is generated from `clk_in`.

## Structure
- Shared package `clk_div_pkg`:
  - state enum {IDLE, WAIT_RISE, MEASURE, DONE};
  - default `CNT_W`;
  - default `TIMEOUT_CYC`.
- The divider-side `ratio` width uses `CNT_W` from `clk_div_pkg`.
- One sub-module, `sync_edge_detect`: parameterised SYNC_STAGES flop chain plus `rise`/`fall` outputs, using synchronous active-high reset. It is reusable for other asynchronous inputs.
- The FSM, counter and compare stay in the top level.

## Test plan
- Divider ratio = 10 drives `div_clk`; `start` with expected = 10, tol = 0 -> `period` = 10, `high_time` = 5, `mismatch` = 0, `timeout` = 0, exactly one `meas_valid`.
- Ratio = 7, expected = 7 -> `period` = 7, `high_time` = 4, `mismatch` = 0.
- Ratio = 12, expected = 10: tol = 1 -> `mismatch` = 1; repeat with tol = 2 -> `mismatch` = 0.
- `div_clk` held at 0; `start` -> `meas_valid` with `timeout` = 1, `mismatch` = 1, `period` = 0, arriving TIMEOUT_CYC + 1 cycles after `start`.
- `continuous` = 1, ratio = 10 -> `meas_valid` every 10 cycles, `period` = 10 each time; a `start` pulse during the run has no effect.
- `reset` asserted midway through MEASURE -> `busy` = 0 on the next cycle, no `meas_valid`, all outputs 0; a fresh `start` then measures correctly.
